// File: rtl/spi_tx_arbiter.sv
// Two-requester SPI transmit arbiter: round-robin grant, byte latch, slave
// select and inter-transaction gap. Every output is driven from a flop.
// Optional WAIT timeout is compiled in when SPI_ARB_TIMEOUT_EN is defined.
module spi_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] ack,
  output logic       spi_start,
  output logic [7:0] spi_din,
  input  logic       spi_done,
  output logic [1:0] cs_n,
  output logic       busy,
  output logic       err
);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  GapLast     = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StGap} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  din_q, din_d;
  logic [1:0]  ack_d, cs_n_d;
  logic        err_d, start_d, busy_d;

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    din_d   = din_q;
    ack_d   = 2'b00;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          // With both requesting, the one not served last wins.
          grant_d = (req == 2'b11) ? ~last_q : req[1];
          last_d  = grant_d;
          din_d   = grant_d ? data1 : data0;
          cnt_d   = 16'd0;
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (spi_done) begin
          ack_d[grant_q] = 1'b1;
          gap_d          = 4'd0;
          state_d        = StGap;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          gap_d          = 4'd0;
          state_d        = StGap;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else                  gap_d   = gap_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase

    start_d = (state_d == StLaunch);
    busy_d  = (state_d != StIdle);
    cs_n_d  = 2'b11;
    if ((state_d == StLaunch) || (state_d == StWait)) cs_n_d[grant_d] = 1'b0;
  end

  // State and output registers; reset leaves requester 0 favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 16'd0;
      gap_q     <= 4'd0;
      din_q     <= 8'h00;
      ack       <= 2'b00;
      err       <= 1'b0;
      spi_start <= 1'b0;
      cs_n      <= 2'b11;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      din_q     <= din_d;
      ack       <= ack_d;
      err       <= err_d;
      spi_start <= start_d;
      cs_n      <= cs_n_d;
      busy      <= busy_d;
    end
  end

  assign spi_din = din_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: directed transaction table plus
// hand-written reset, stray-done, back-to-back and timeout sequences.
module tb_spi_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] data0, data1;
  logic [1:0] ack;
  logic       spi_start;
  logic [7:0] spi_din;
  logic       spi_done;
  logic [1:0] cs_n;
  logic       busy;
  logic       err;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int launch_cyc;
  bit both_low = 1'b0;

  spi_tx_arbiter #(
    .TIMEOUT_CYCLES(20),
    .GAP_CYCLES    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .ack      (ack),
    .spi_start(spi_start),
    .spi_din  (spi_din),
    .spi_done (spi_done),
    .cs_n     (cs_n),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (cs_n === 2'b00) both_low = 1'b1;

  typedef struct {
    logic [1:0] r;
    logic [7:0] d0;
    logic [7:0] d1;
    int         wlen;
    bit         drop;
    logic [1:0] exp_cs;
    logic [7:0] exp_din;
    logic [1:0] exp_ack;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // One transaction starting from IDLE; ends in the IDLE cycle after GAP.
  task automatic txn(input string nm, input logic [1:0] r, input logic [7:0] d0,
                     input logic [7:0] d1, input int wlen, input bit drop, input bit keep,
                     input logic [1:0] exp_cs, input logic [7:0] exp_din,
                     input logic [1:0] exp_ack);
    bit bad = 1'b0;
    req = r; data0 = d0; data1 = d1;
    step();
    chk({nm, " start"}, 32'(spi_start), 32'd1);
    chk({nm, " cs_launch"}, 32'(cs_n), 32'(exp_cs));
    chk({nm, " din"}, 32'(spi_din), 32'(exp_din));
    launch_cyc = cyc;
    step();
    chk({nm, " start_low"}, 32'(spi_start), 32'd0);
    if (drop) req = 2'b00;
    for (int i = 1; i <= wlen; i++) begin
      if (cs_n !== exp_cs || spi_din !== exp_din || ack !== 2'b00 || busy !== 1'b1) bad = 1'b1;
      if (i == wlen) spi_done = 1'b1;
      step();
    end
    spi_done = 1'b0;
    chk({nm, " wait_hold"}, 32'(bad), 32'd0);
    chk({nm, " ack"}, 32'(ack), 32'(exp_ack));
    chk({nm, " cs_gap"}, 32'(cs_n), 32'h3);
    chk({nm, " err"}, 32'(err), 32'd0);
    if (!keep) req = 2'b00;
    step();
    chk({nm, " gap2"}, {28'd0, ack, busy, cs_n[0] & cs_n[1]}, 32'h3);
    step();
    chk({nm, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s1;
    bit bad;
    vecs[0] = '{2'b01, 8'hA5, 8'h00, 16, 1'b0, 2'b10, 8'hA5, 2'b01};
    vecs[1] = '{2'b10, 8'h00, 8'h3C, 4,  1'b0, 2'b01, 8'h3C, 2'b10};
    vecs[2] = '{2'b11, 8'h11, 8'h22, 3,  1'b0, 2'b10, 8'h11, 2'b01};
    vecs[3] = '{2'b11, 8'h33, 8'h44, 2,  1'b0, 2'b01, 8'h44, 2'b10};
    vecs[4] = '{2'b01, 8'h5A, 8'h00, 5,  1'b1, 2'b10, 8'h5A, 2'b01};
    vecs[5] = '{2'b10, 8'h00, 8'hC3, 1,  1'b0, 2'b01, 8'hC3, 2'b10};
    vecs[6] = '{2'b11, 8'h77, 8'h88, 2,  1'b0, 2'b10, 8'h77, 2'b01};

    rst = 1'b1; req = 2'b00; data0 = 8'h00; data1 = 8'h00; spi_done = 1'b0;
    step();
    step();
    chk("rst cs_n", 32'(cs_n), 32'h3);
    chk("rst start", 32'(spi_start), 32'd0);
    chk("rst ack_err", {30'd0, ack}, 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst din", 32'(spi_din), 32'h00);
    rst = 1'b0;
    step();

    // Contention: requests held across three transactions.
    txn("cont0", 2'b11, 8'hA1, 8'hB2, 2, 1'b0, 1'b1, 2'b10, 8'hA1, 2'b01);
    txn("cont1", 2'b11, 8'hA1, 8'hB2, 2, 1'b0, 1'b1, 2'b01, 8'hB2, 2'b10);
    txn("cont2", 2'b11, 8'hA1, 8'hB2, 2, 1'b0, 1'b0, 2'b10, 8'hA1, 2'b01);

    for (int i = 0; i < 7; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].d0, vecs[i].d1, vecs[i].wlen,
          vecs[i].drop, 1'b0, vecs[i].exp_cs, vecs[i].exp_din, vecs[i].exp_ack);
    end

    // Back-to-back on requester 0: launch spacing = 3 + 1 + 2 + 1.
    txn("b2b0", 2'b01, 8'h66, 8'h00, 3, 1'b0, 1'b1, 2'b10, 8'h66, 2'b01);
    s1 = launch_cyc;
    txn("b2b1", 2'b01, 8'h66, 8'h00, 3, 1'b0, 1'b0, 2'b10, 8'h66, 2'b01);
    chk("b2b spacing", 32'(launch_cyc - s1), 32'd7);

    // Stray spi_done in IDLE and in GAP.
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("stray idle", {28'd0, ack, busy, spi_start}, 32'd0);
    req = 2'b10; data1 = 8'h9E;
    step();
    step();
    spi_done = 1'b1;
    step();
    chk("stray ack", 32'(ack), 32'h2);
    req = 2'b00;
    step();
    spi_done = 1'b0;
    chk("stray gap", {28'd0, ack, busy, spi_start}, 32'h2);
    step();
    chk("stray gap idle", 32'(busy), 32'd0);

    // Reset in WAIT aborts with no ack; a later spi_done is ignored.
    req = 2'b01; data0 = 8'hD4;
    step();
    step();
    step();
    rst = 1'b1; req = 2'b00;
    step();
    rst = 1'b0;
    chk("rstwait cs_busy", {29'd0, cs_n, busy}, 32'h6);
    chk("rstwait ack_err", {29'd0, ack, err}, 32'd0);
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("rstwait late done", {29'd0, ack, busy}, 32'd0);
    txn("after_rst", 2'b10, 8'h00, 8'h3C, 3, 1'b0, 1'b0, 2'b01, 8'h3C, 2'b10);

`ifdef SPI_ARB_TIMEOUT_EN
    // Timeout after 20 WAIT cycles.
    req = 2'b01; data0 = 8'hE1;
    step();
    step();
    bad = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (err !== 1'b0 || ack !== 2'b00 || cs_n !== 2'b10) bad = 1'b1;
      step();
    end
    chk("tmo early", 32'(bad), 32'd0);
    chk("tmo wait20", {29'd0, err, cs_n}, 32'h2);
    step();
    chk("tmo err", 32'(err), 32'd1);
    chk("tmo ack", 32'(ack), 32'h1);
    chk("tmo cs", 32'(cs_n), 32'h3);
    req = 2'b00;
    step();
    chk("tmo err pulse", 32'(err), 32'd0);
    step();
    // spi_done on the limit cycle wins.
    req = 2'b10; data1 = 8'hF2;
    step();
    step();
    for (int i = 0; i < 19; i++) step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("tmo tie err", 32'(err), 32'd0);
    chk("tmo tie ack", 32'(ack), 32'h2);
    req = 2'b00;
    step();
    step();
`else
    // Without the timeout, WAIT persists indefinitely.
    req = 2'b01; data0 = 8'hE1;
    step();
    step();
    bad = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (busy !== 1'b1 || err !== 1'b0 || ack !== 2'b00 || cs_n !== 2'b10) bad = 1'b1;
      step();
    end
    chk("notmo hold", 32'(bad), 32'd0);
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("notmo ack", 32'(ack), 32'h1);
    req = 2'b00;
    step();
    step();
`endif
    chk("notmo idle", 32'(busy), 32'd0);
    chk("cs never 00", 32'(both_low), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, WAIT-state cycle limit before abort (1..65535).
REQ-002 Parameter: GAP_CYCLES, 2, idle cycles with all cs_n high between transactions (1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester transaction request; held high with data stable until matching ack.
REQ-006 data0 / data1  input  8 each  byte to transmit for requester 0 / 1.
REQ-007 ack  output  2  one-cycle completion pulse to the served requester.
REQ-008 spi_start  output  1  one-cycle launch pulse to the SPI shifter.
REQ-009 spi_din  output  8  latched byte for the shifter, stable from launch until completion.
REQ-010 spi_done  input  1  one-cycle shifter completion pulse.
REQ-011 cs_n  output  2  active-low slave selects; requester i owns slave i.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err  output  1  one-cycle timeout-abort pulse.

Function
REQ-014 The block SHALL implement states IDLE, LAUNCH, WAIT, GAP; all outputs registered.
REQ-015 IDLE: when any req bit is high at edge k, the block SHALL latch grant index and data and enter LAUNCH, spi_start=1 and cs_n[g]=0 in cycle k+1 (1-cycle latency).
REQ-016 Arbitration SHALL be round-robin: with both req high, the requester not served last wins; first arbitration after reset favours requester 0.
REQ-017 LAUNCH SHALL last exactly one cycle, then WAIT; spi_start SHALL be 0 in all other states.
REQ-018 WAIT: cs_n[g] SHALL stay low and spi_din stable; spi_done high at edge m SHALL give ack[g]=1, cs_n=2'b11 and entry to GAP in cycle m+1.
REQ-019 GAP SHALL hold cs_n=2'b11 for exactly GAP_CYCLES cycles, then IDLE; requests are not sampled in GAP.
REQ-020 spi_done outside WAIT SHALL be ignored.
REQ-021 Deassertion of req[g] during LAUNCH/WAIT SHALL NOT abort; ack[g] still pulses.
REQ-022 At most one cs_n bit SHALL be low in any cycle; the ungranted bit stays high.
REQ-023 Cycle counter SHALL be 16 bits, cleared on LAUNCH entry, saturating, never wrapping.

Reset
REQ-024 With rst high at an edge, the next cycle SHALL show state IDLE, cs_n=2'b11, spi_start=0, ack=0, err=0, busy=0, spi_din=8'h00, round-robin pointer favouring requester 0.
REQ-025 Reset mid-transaction SHALL abort without ack or err pulse; cs_n high next cycle.

Configuration
REQ-026 Macro SPI_ARB_TIMEOUT_EN defined: in WAIT, after TIMEOUT_CYCLES cycles without spi_done, the block SHALL pulse err and ack[g] together, raise cs_n, enter GAP; spi_done in the same cycle as the limit wins (no err).
REQ-027 Macro undefined: no timeout logic; err tied 0; WAIT persists until spi_done or reset.

Verification
REQ-028 Single request: req=2'b01, data0=8'hA5, spi_done 16 cycles after spi_start -> spi_din=8'hA5, cs_n=2'b10 during WAIT, ack=2'b01 one cycle, GAP 2 cycles, busy low after.
REQ-029 Contention: req=2'b11 held across three transactions -> grants 0,1,0; cs_n 2'b10,2'b01,2'b10; never 2'b00.
REQ-030 Back-to-back: req0 held continuously -> spi_start pulses spaced by WAIT length + 1 + GAP_CYCLES + 1 cycles.
REQ-031 Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20): no spi_done -> err and ack pulse together 20 cycles into WAIT; undefined build -> busy stays high 100+ cycles.
REQ-032 Reset in WAIT: rst pulsed mid-transfer -> next cycle cs_n=2'b11, busy=0, no ack; next req1 served normally.
REQ-033 Stray spi_done in IDLE and GAP -> no ack, no state change.
